// File: rtl/lcd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | lcd_pkg
// | Shared types, constants and frame word-map helpers for the LCD frame feeder.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [1:0] {
    INIT_WAIT = 2'd0,
    INIT_RUN  = 2'd1,
    IDLE      = 2'd2,
    STREAM    = 2'd3
  } state_t;

  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam int LCD_COLS    = 16;
  localparam int LCD_ROWS    = 2;
  localparam int LCD_CELLS   = LCD_COLS * LCD_ROWS;
  localparam int FRAME_WORDS = LCD_CELLS + LCD_ROWS;

  localparam logic [5:0] LAST_IDX  = 6'(FRAME_WORDS - 1);
  localparam logic [5:0] LINE2_IDX = 6'(LCD_COLS + 1);

  // Buffer cell shown by frame word idx (result unused for the two command slots).
  function automatic logic [4:0] cell_of(input logic [5:0] idx);
    logic [5:0] c;
    c = (idx <= 6'(LCD_COLS)) ? idx - 6'd1 : idx - 6'd2;
    return c[4:0];
  endfunction

  function automatic logic [8:0] word_of(input logic [5:0] idx, input logic [7:0] ch);
    if (idx == 6'd0) begin
      return {1'b0, LCD_CMD_LINE1};
    end else if (idx == LINE2_IDX) begin
      return {1'b0, LCD_CMD_LINE2};
    end else begin
      return {1'b1, ch};
    end
  endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_frame_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | lcd_frame_buffer
// | 2x16 character register file: one write port, one combinational read port.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module lcd_frame_buffer
  import lcd_pkg::*;
#(
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       clock_i,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic [4:0] wr_addr_i,
  input  logic [7:0] wr_char_i,
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_char_o
);

  logic [7:0] cells_q [LCD_CELLS];

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LCD_CELLS; i++) begin
        cells_q[i] <= BLANK_CHAR;
      end
    end else if (wr_en_i) begin
      cells_q[wr_addr_i] <= wr_char_i;
    end
  end

  assign rd_char_o = cells_q[rd_addr_i];

endmodule : lcd_frame_buffer
`default_nettype wire

// File: rtl/lcd_frame_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | lcd_frame_feeder
// | Streams cursor commands plus a 2x16 frame buffer into the 9-bit LCD write
// | engine, one word per busy_flag rising edge. Optional macro AUTO_REFRESH_EN
// | makes every buffer write also request a refresh.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module lcd_frame_feeder
  import lcd_pkg::*;
#(
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         ACK_TIMEOUT = 200_000,
  parameter logic [8:0] IDLE_WORD   = 9'h000,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic       clock,
  input  logic       internal_reset_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       refresh_req,
  input  logic       busy_flag,
  output logic [8:0] lcd_d_in,
  output logic       data_ready,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       err_timeout
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  if (ACK_TIMEOUT < 1 || CLK_FREQ < 1) begin : g_bad_params
    $error("lcd_frame_feeder: ACK_TIMEOUT and CLK_FREQ must be positive");
  end

  state_t           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             busy_q;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [8:0]       lcd_q, lcd_d;
  logic             data_ready_q, data_ready_d;
  logic             frame_busy_q, frame_busy_d;
  logic             frame_done_q, frame_done_d;
  logic             err_q, err_d;

  logic       w_rise, w_fall, w_start, w_auto_req;
  logic [5:0] w_next_idx;
  logic [4:0] w_rd_addr;
  logic [7:0] w_rd_char;
  logic [8:0] w_next_word;

`ifdef AUTO_REFRESH_EN
  assign w_auto_req = wr_en;
`else
  assign w_auto_req = 1'b0;
`endif

  assign w_rise = busy_flag & ~busy_q;
  assign w_fall = ~busy_flag & busy_q;

  // The read port always looks one word ahead so the next load is ready on consumption.
  assign w_next_idx  = (state_q == STREAM) ? idx_q + 6'd1 : 6'd0;
  assign w_rd_addr   = cell_of(w_next_idx);
  assign w_next_word = word_of(w_next_idx, w_rd_char);

  lcd_frame_buffer #(
    .BLANK_CHAR (BLANK_CHAR)
  ) u_buffer (
    .clock_i   (clock),
    .rst_ni    (internal_reset_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_char_i (wr_char),
    .rd_addr_i (w_rd_addr),
    .rd_char_o (w_rd_char)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    lcd_d        = lcd_q;
    data_ready_d = 1'b0;
    frame_done_d = 1'b0;
    frame_busy_d = frame_busy_q;
    err_d        = err_q;
    w_start      = 1'b0;

    case (state_q)
      INIT_WAIT: begin
        if (w_rise) state_d = INIT_RUN;
      end
      INIT_RUN: begin
        if (w_fall) state_d = IDLE;
      end
      IDLE: begin
        lcd_d = IDLE_WORD;
        // Start only while busy is high so the engine latches word 0 on its next fall.
        if (pending_q && busy_flag) begin
          w_start      = 1'b1;
          lcd_d        = w_next_word;
          data_ready_d = 1'b1;
          idx_d        = 6'd0;
          tmo_d        = '0;
          frame_busy_d = 1'b1;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (w_rise) begin
          tmo_d = '0;
          if (idx_q < LAST_IDX) begin
            idx_d        = w_next_idx;
            lcd_d        = w_next_word;
            data_ready_d = 1'b1;
          end else begin
            lcd_d        = IDLE_WORD;
            frame_busy_d = 1'b0;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_d        = '0;
          err_d        = 1'b1;
          lcd_d        = IDLE_WORD;
          frame_busy_d = 1'b0;
          state_d      = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = INIT_WAIT;
    endcase
  end

  // A request arriving on the start cycle is kept: it belongs to the next frame.
  assign pending_d = (pending_q & ~w_start) | refresh_req | w_auto_req;

  always_ff @(posedge clock or negedge internal_reset_n) begin
    if (!internal_reset_n) begin
      state_q      <= INIT_WAIT;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      tmo_q        <= '0;
      lcd_q        <= IDLE_WORD;
      data_ready_q <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      busy_q       <= busy_flag;
      tmo_q        <= tmo_d;
      lcd_q        <= lcd_d;
      data_ready_q <= data_ready_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign lcd_d_in    = lcd_q;
  assign data_ready  = data_ready_q;
  assign frame_busy  = frame_busy_q;
  assign frame_done  = frame_done_q;
  assign err_timeout = err_q;

endmodule : lcd_frame_feeder
`default_nettype wire

// File: tb/tb_lcd_frame_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_lcd_frame_feeder
// | Directed self-checking bench with a simple LCD engine busy model.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_lcd_frame_feeder;

  localparam int ACK = 300;

  logic       clock = 1'b0;
  logic       internal_reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       refresh_req = 1'b0;
  logic       busy_flag = 1'b0;
  logic [8:0] lcd_d_in;
  logic       data_ready, frame_busy, frame_done, err_timeout;

  int n_assert = 0;
  int n_fail   = 0;
  int dr_cnt   = 0;
  int fd_cnt   = 0;
  logic       mon_en = 1'b0;
  logic [8:0] prev_lcd = 9'h000;
  logic [8:0] log_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] tb_buf [32];

  lcd_frame_feeder #(
    .ACK_TIMEOUT (ACK)
  ) dut (
    .clock            (clock),
    .internal_reset_n (internal_reset_n),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_char          (wr_char),
    .refresh_req      (refresh_req),
    .busy_flag        (busy_flag),
    .lcd_d_in         (lcd_d_in),
    .data_ready       (data_ready),
    .frame_busy       (frame_busy),
    .frame_done       (frame_done),
    .err_timeout      (err_timeout)
  );

  always #5 clock = ~clock;

  // Pulse counters and word-stability watch: a new word may only appear while busy is high.
  always @(negedge clock) begin
    if (data_ready === 1'b1) dr_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    if (mon_en && internal_reset_n && (lcd_d_in !== prev_lcd)) begin
      n_assert++;
      if (busy_flag !== 1'b1) begin
        n_fail++;
        $display("FAIL word_stable: lcd_d_in changed to %h with busy_flag=%b, required busy_flag=1",
                 lcd_d_in, busy_flag);
      end
    end
    prev_lcd = lcd_d_in;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic write_cell(input logic [4:0] a, input logic [7:0] c);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    tick(1);
    wr_en = 1'b0;
    tb_buf[a] = c;
  endtask

  task automatic pulse_refresh();
    refresh_req = 1'b1;
    tick(1);
    refresh_req = 1'b0;
  endtask

  // Engine model: each write holds busy for hi cycles, latches the word at the fall.
  task automatic engine_words(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      busy_flag = 1'b1;
      tick(hi);
      if (lcd_d_in !== 9'h000) log_q.push_back(lcd_d_in);
      busy_flag = 1'b0;
      tick(lo);
    end
  endtask

  task automatic add_frame();
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, tb_buf[i]});
    exp_q.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, tb_buf[i]});
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
    tick(2);
    n_assert++;
    if (lcd_d_in !== 9'h000) begin n_fail++; $display("FAIL reset_lcd: got %h required 000", lcd_d_in); end
    n_assert++;
    if ({data_ready, frame_busy, frame_done, err_timeout} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 0000", {data_ready, frame_busy, frame_done, err_timeout});
    end
    internal_reset_n = 1'b1;
    tick(2);
    mon_en = 1'b1;
  endtask

  task automatic test_init_and_blank_frame();
    int fd0, dr0;
    busy_flag = 1'b1;
    tick(50);
    pulse_refresh();
    tick(49);
    n_assert++;
    if (lcd_d_in !== 9'h000) begin n_fail++; $display("FAIL init_lcd: got %h required 000", lcd_d_in); end
    busy_flag = 1'b0;
    tick(5);
    n_assert++;
    if ({lcd_d_in, frame_busy} !== {9'h000, 1'b0}) begin
      n_fail++; $display("FAIL idle_wait: got lcd=%h busy=%b required 000/0", lcd_d_in, frame_busy);
    end
    log_q.delete(); exp_q.delete(); add_frame();
    fd0 = fd_cnt; dr0 = dr_cnt;
    engine_words(35, 3, 3);
    n_assert++;
    if (log_q.size() !== 34) begin n_fail++; $display("FAIL blank_frame_len: got %0d required 34", log_q.size()); end
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      n_assert++;
      if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL blank_word[%0d]: got %h required %h", i, log_q[i], exp_q[i]); end
    end
    n_assert++;
    if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL blank_done: got %0d required 1", fd_cnt - fd0); end
    n_assert++;
    if (dr_cnt - dr0 !== 34) begin n_fail++; $display("FAIL blank_ready: got %0d required 34", dr_cnt - dr0); end
    n_assert++;
    if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL blank_fbusy: got %b required 0", frame_busy); end
  endtask

  task automatic test_hello_world();
    int fd0;
    logic [7:0] hello [5];
    logic [7:0] world [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    world = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
    for (int i = 0; i < 5; i++) write_cell(5'(i), hello[i]);
    for (int i = 0; i < 5; i++) write_cell(5'(16 + i), world[i]);
    pulse_refresh();
    log_q.delete(); exp_q.delete(); add_frame();
    fd0 = fd_cnt;
    engine_words(35, 3, 3);
    n_assert++;
    if (log_q.size() !== 34) begin n_fail++; $display("FAIL hello_len: got %0d required 34", log_q.size()); end
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      n_assert++;
      if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hello_word[%0d]: got %h required %h", i, log_q[i], exp_q[i]); end
    end
    if (log_q.size() == 34) begin
      n_assert++;
      if ({log_q[1], log_q[6], log_q[17], log_q[18]} !== {9'h148, 9'h120, 9'h0C0, 9'h157}) begin
        n_fail++; $display("FAIL hello_literals: got %h %h %h %h required 148 120 0c0 157",
                           log_q[1], log_q[6], log_q[17], log_q[18]);
      end
    end
    n_assert++;
    if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL hello_done: got %0d required 1", fd_cnt - fd0); end
  endtask

  task automatic test_back_to_back();
    int fd0, dr0;
    pulse_refresh();
    log_q.delete(); exp_q.delete(); add_frame(); add_frame();
    fd0 = fd_cnt; dr0 = dr_cnt;
    engine_words(10, 3, 3);
    pulse_refresh();
    tick(2);
    pulse_refresh();
    engine_words(59, 3, 3);
    engine_words(5, 3, 3);
    n_assert++;
    if (log_q.size() !== 68) begin n_fail++; $display("FAIL b2b_len: got %0d required 68", log_q.size()); end
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      n_assert++;
      if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h required %h", i, log_q[i], exp_q[i]); end
    end
    n_assert++;
    if (fd_cnt - fd0 !== 2) begin n_fail++; $display("FAIL b2b_done: got %0d required 2", fd_cnt - fd0); end
    n_assert++;
    if (dr_cnt - dr0 !== 68) begin n_fail++; $display("FAIL b2b_ready: got %0d required 68", dr_cnt - dr0); end
  endtask

  task automatic test_timeout();
    int fd0;
    mon_en = 1'b0;
    pulse_refresh();
    fd0 = fd_cnt;
    engine_words(5, 3, 3);
    tick(ACK / 2);
    n_assert++;
    if ({err_timeout, frame_busy} !== 2'b01) begin
      n_fail++; $display("FAIL tmo_early: got err=%b fbusy=%b required 0/1", err_timeout, frame_busy);
    end
    tick(ACK / 2 + 20);
    n_assert++;
    if ({err_timeout, frame_busy, lcd_d_in} !== {1'b1, 1'b0, 9'h000}) begin
      n_fail++; $display("FAIL tmo_abort: got err=%b fbusy=%b lcd=%h required 1/0/000", err_timeout, frame_busy, lcd_d_in);
    end
    n_assert++;
    if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL tmo_no_done: got %0d required 0", fd_cnt - fd0); end
    mon_en = 1'b1;
    pulse_refresh();
    log_q.delete(); exp_q.delete(); add_frame();
    engine_words(35, 3, 3);
    n_assert++;
    if (log_q.size() !== 34) begin n_fail++; $display("FAIL tmo_recover_len: got %0d required 34", log_q.size()); end
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      n_assert++;
      if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL tmo_word[%0d]: got %h required %h", i, log_q[i], exp_q[i]); end
    end
    n_assert++;
    if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b required 1", err_timeout); end
  endtask

  task automatic test_reset_mid_frame();
    pulse_refresh();
    engine_words(11, 3, 3);
    mon_en = 1'b0;
    #2 internal_reset_n = 1'b0;
    #1;
    n_assert++;
    if ({lcd_d_in, data_ready, frame_busy, frame_done, err_timeout} !== {9'h000, 4'b0000}) begin
      n_fail++; $display("FAIL rst_mid: got lcd=%h flags=%b required 000/0000", lcd_d_in,
                         {data_ready, frame_busy, frame_done, err_timeout});
    end
    for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
    tick(1);
    internal_reset_n = 1'b1;
    tick(2);
    mon_en = 1'b1;
    pulse_refresh();
    busy_flag = 1'b1;
    tick(10);
    n_assert++;
    if ({lcd_d_in, frame_busy} !== {9'h000, 1'b0}) begin
      n_fail++; $display("FAIL rst_init_absorb: got lcd=%h fbusy=%b required 000/0", lcd_d_in, frame_busy);
    end
    busy_flag = 1'b0;
    tick(3);
    log_q.delete(); exp_q.delete(); add_frame();
    engine_words(35, 3, 3);
    n_assert++;
    if (log_q.size() !== 34) begin n_fail++; $display("FAIL rst_frame_len: got %0d required 34", log_q.size()); end
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      n_assert++;
      if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_word[%0d]: got %h required %h", i, log_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_auto_refresh();
    int fd0;
    write_cell(5'd5, 8'h41);
    log_q.delete();
    fd0 = fd_cnt;
    engine_words(35, 3, 3);
`ifdef AUTO_REFRESH_EN
    n_assert++;
    if (log_q.size() !== 34) begin n_fail++; $display("FAIL auto_len: got %0d required 34", log_q.size()); end
    n_assert++;
    if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL auto_done: got %0d required 1", fd_cnt - fd0); end
`else
    n_assert++;
    if (log_q.size() !== 0) begin n_fail++; $display("FAIL noauto_len: got %0d required 0", log_q.size()); end
    n_assert++;
    if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL noauto_done: got %0d required 0", fd_cnt - fd0); end
    pulse_refresh();
    log_q.delete();
    engine_words(35, 3, 3);
`endif
    n_assert++;
    if (log_q.size() !== 34) begin
      n_fail++; $display("FAIL write_a_len: got %0d required 34", log_q.size());
    end else begin
      n_assert++;
      if ({log_q[5], log_q[6], log_q[7]} !== {9'h120, 9'h141, 9'h120}) begin
        n_fail++; $display("FAIL write_a_cell: got %h %h %h required 120 141 120", log_q[5], log_q[6], log_q[7]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_and_blank_frame();
    test_hello_world();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    test_auto_refresh();
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_lcd_frame_feeder
`default_nettype wire
